i2c_slv_ctrl: RTL and testbench
===============================

I2C_SLV_CTRL -- requirements
Module: i2c_slv_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on scl_i/sda_i (min 2).
REQ-002 clk  in  1  system clock.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 ena  in  1  core enable; when 0, FSM is held in IDLE, SDA/SCL are released, and no events fire.
REQ-005 slv_addr  in  7  own 7-bit slave address.
REQ-006 thddat  in  16  clk cycles from SCL falling edge to SDA update.
REQ-007 scl_i, sda_i  in  1 each  raw bus inputs.
REQ-008 scl_o, sda_o  out  1 each  open-drain outputs; 1 = release, 0 = pull low.
REQ-009 tx_data  in  8  byte to send on a master read.
REQ-010 tx_valid  in  1  tx_data is valid; consumed by a tx_ready pulse.
REQ-011 tx_ready  out  1  1-cycle pulse when tx_data is loaded into the shift register.
REQ-012 rx_data  out  8  last received data byte.
REQ-013 rx_valid  out  1  1-cycle pulse when rx_data is updated.
REQ-014 addressed  out  1  high from own-address ACK until the next START or STOP.
REQ-015 rw  out  1  R/W bit of the current transfer (1 = master read).
REQ-016 sta_det, sto_det  out  1 each  1-cycle pulses on bus START (including repeated START) and on STOP.
REQ-017 nack_det  out  1  1-cycle pulse when the master NACKs a transmitted byte.

Function
REQ-018 scl_i and sda_i SHALL pass through the SYNC_STAGES synchronizer; edges SHALL be detected on the synchronized values.
REQ-019 START SHALL be detected as sda falling while scl=1; STOP SHALL be detected as sda rising while scl=1. Both SHALL be flagged one cycle after the synchronized edge.
REQ-020 FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
REQ-021 START from any state SHALL cause: go to ADDR, clear the bit counter, clear addressed.
REQ-022 STOP from any state SHALL cause: go to IDLE, release both lines.
REQ-023 ADDR SHALL sample sda on 8 SCL rising edges, MSB first. After the 8th bit: if addr[7:1]==slv_addr, go to ADDR_ACK and latch rw; otherwise go to IGNORE.
REQ-024 On the SCL falling edge after a bit, sda_o SHALL change exactly thddat cycles later. Any drive SHALL be released on the SCL falling edge that ends the ACK or bit.
REQ-025 ADDR_ACK SHALL drive sda_o=0 for one SCL high period, then go to TX if rw=1, otherwise to RX.
REQ-026 RX SHALL shift 8 bits, then raise rx_valid on the 8th SCL rising edge and go to RX_ACK, which drives an ACK (sda_o=0).
REQ-027 TX entry (after the ACK falling edge): if tx_valid=1, load tx_data and pulse tx_ready; otherwise hold scl_o=0 (stretch) until tx_valid=1, then load and release scl_o after thddat cycles.
REQ-028 TX SHALL drive bits MSB first. TX_ACK SHALL release SDA and sample on SCL rising: ACK (0) returns to TX; NACK (1) pulses nack_det and goes to IGNORE.
REQ-029 IGNORE SHALL keep SDA and SCL released until START or STOP.
REQ-030 rx_valid and tx_ready SHALL never be asserted while ena=0.
REQ-031 The thddat counter SHALL be 16 bits and saturate. thddat=0 SHALL mean SDA updates in the cycle after the falling edge is detected.

Reset
REQ-032 On rstn low: state=IDLE; scl_o=sda_o=1; rx_data=0; all pulses 0; addressed=0; rw=0; synchronizers=1.
REQ-033 Reset asserted mid-transfer SHALL release the bus within the same cycle (asynchronous).

Structure
REQ-034 State encodings and the address-width constant SHALL live in the shared package/define file beside the I2C command codes.
REQ-035 Synchronizer plus START/STOP/edge detection SHALL be one sub-module, i2c_slv_bus_det.

Verification
REQ-036 slv_addr=0x42, master writes 0x84 then 0xA5 -> ACK on the address and on both bytes; rx_valid twice with rx_data 0xA5 last; rw=0.
REQ-037 Master reads from 0x42 with tx_valid held: tx_data 0x3C then 0xC3, master ACKs then NACKs -> SDA shows 0x3C, 0xC3; tx_ready twice; nack_det once; state IGNORE.
REQ-038 Address 0x43 while slv_addr=0x42 -> no ACK (SDA stays 1), addressed=0, no rx_valid/tx_ready until STOP.
REQ-039 Read with tx_valid low for 500 cycles -> scl_o=0 for ≥500 cycles; SCL released thddat cycles after tx_valid rises.
REQ-040 Repeated START after the 1st written byte, then a read from 0x42 -> sta_det pulses twice; rw switches to 1; TX path active.
REQ-041 rstn pulsed low during the RX bit-4 high phase -> scl_o=sda_o=1 immediately; next START and address are accepted normally.

Source files
------------

// File: rtl/i2c_slv_pkg.sv
// Shared definitions for the I2C slave controller: FSM encoding, address width
// and the R/W command codes carried in bit 0 of the address byte.
package i2c_slv_pkg;

  localparam int ADDR_W = 7;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_slv_bus_det.sv
// Bus front end: synchronizes raw SCL/SDA and turns their edges into
// registered single-cycle SCL rise/fall and START/STOP events.
module i2c_slv_bus_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sta,
  output logic sto
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Idle bus is high, so synchronizers come out of reset released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // Events are registered so they all land one cycle after the synchronized edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sda      <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      sta      <= 1'b0;
      sto      <= 1'b0;
    end else begin
      sda      <= sda_s;
      scl_rise <= scl_s & ~scl_q;
      scl_fall <= ~scl_s & scl_q;
      sta      <= scl_s & scl_q & sda_q & ~sda_s;
      sto      <= scl_s & scl_q & ~sda_q & sda_s;
    end
  end

endmodule

// File: rtl/i2c_slv_ctrl.sv
// I2C slave controller: 7-bit address match, byte receive/transmit with ACK
// handling, programmable SDA hold time and clock stretching on empty TX data.
module i2c_slv_ctrl
  import i2c_slv_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ena,
  input  logic [ADDR_W-1:0] slv_addr,
  input  logic [15:0]       thddat,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_o,
  output logic              sda_o,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              addressed,
  output logic              rw,
  output logic              sta_det,
  output logic              sto_det,
  output logic              nack_det
);

  state_t      state, state_n;
  logic        sda_smp, rise_raw, fall_raw, sta_raw, sto_raw;
  logic        rise, fall, sta, sto;
  logic [7:0]  shreg, byte_in;
  logic [3:0]  bit_cnt;
  logic        ack_hi, wait_tx, pend, pend_val, pend_scl;
  logic [15:0] hold_cnt;

  logic bit_clr, bit_inc, ack_set, ack_clr, sh_in, rx_done, addr_hit, rel_sda;
  logic drv_req, drv_val, tx_start, tx_load, stretch, tx_shift, nack, bus_rel;

  i2c_slv_bus_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_det (
    .clk      (clk),
    .rstn     (rstn),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_smp),
    .scl_rise (rise_raw),
    .scl_fall (fall_raw),
    .sta      (sta_raw),
    .sto      (sto_raw)
  );

  assign rise    = rise_raw & ena;
  assign fall    = fall_raw & ena;
  assign sta     = sta_raw & ena;
  assign sto     = sto_raw & ena;
  assign sta_det = sta;
  assign sto_det = sto;
  assign byte_in = {shreg[6:0], sda_smp};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    ack_set  = 1'b0;
    ack_clr  = 1'b0;
    sh_in    = 1'b0;
    rx_done  = 1'b0;
    addr_hit = 1'b0;
    rel_sda  = 1'b0;
    drv_req  = 1'b0;
    drv_val  = 1'b1;
    tx_start = 1'b0;
    tx_load  = 1'b0;
    stretch  = 1'b0;
    tx_shift = 1'b0;
    nack     = 1'b0;
    bus_rel  = 1'b0;
    if (!ena) begin
      state_n = IDLE;
      bus_rel = 1'b1;
    end else if (sta) begin
      state_n = ADDR;
      bit_clr = 1'b1;
      bus_rel = 1'b1;
    end else if (sto) begin
      state_n = IDLE;
      bus_rel = 1'b1;
    end else begin
      // Every falling SCL edge ends the current bit, so any drive is dropped here.
      rel_sda = fall;
      unique case (state)
        ADDR: begin
          if (rise) begin
            sh_in   = 1'b1;
            bit_inc = 1'b1;
            if (bit_cnt == 4'd7) begin
              if (byte_in[7:1] == slv_addr) begin
                state_n  = ADDR_ACK;
                addr_hit = 1'b1;
                ack_clr  = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          if (rise) begin
            ack_set = 1'b1;
          end else if (fall) begin
            if (!ack_hi) begin
              drv_req = 1'b1;
              drv_val = 1'b0;
            end else begin
              bit_clr = 1'b1;
              if (state == ADDR_ACK && rw == RW_READ) begin
                state_n  = TX;
                tx_start = 1'b1;
              end else begin
                state_n = RX;
              end
            end
          end
        end
        RX: begin
          if (rise) begin
            sh_in   = 1'b1;
            bit_inc = 1'b1;
            if (bit_cnt == 4'd7) begin
              rx_done = 1'b1;
              state_n = RX_ACK;
              ack_clr = 1'b1;
            end
          end
        end
        TX: begin
          if (wait_tx) begin
            tx_load = tx_valid;
          end else if (rise) begin
            bit_inc = 1'b1;
          end else if (fall) begin
            if (bit_cnt == 4'd8) begin
              state_n = TX_ACK;
              ack_clr = 1'b1;
            end else begin
              tx_shift = 1'b1;
              drv_req  = 1'b1;
              drv_val  = shreg[7];
            end
          end
        end
        TX_ACK: begin
          if (rise) begin
            if (sda_smp) begin
              nack    = 1'b1;
              state_n = IGNORE;
            end else begin
              ack_set = 1'b1;
            end
          end else if (fall && ack_hi) begin
            state_n  = TX;
            bit_clr  = 1'b1;
            tx_start = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (tx_start) begin
      tx_load = tx_valid;
      stretch = ~tx_valid;
    end
    if (tx_load) begin
      drv_req = 1'b1;
      drv_val = tx_data[7];
    end
  end

  // Shift register holds the byte being received, or the TX bits still to send.
  always_ff @(posedge clk) begin
    if (tx_load)       shreg <= {tx_data[6:0], 1'b1};
    else if (tx_shift) shreg <= {shreg[6:0], 1'b1};
    else if (sh_in)    shreg <= byte_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt   <= 4'd0;
      ack_hi    <= 1'b0;
      addressed <= 1'b0;
      rw        <= RW_WRITE;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      nack_det  <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      tx_ready <= tx_load;
      nack_det <= nack;
      if (bit_clr)      bit_cnt <= 4'd0;
      else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;
      if (ack_set)      ack_hi <= 1'b1;
      else if (ack_clr) ack_hi <= 1'b0;
      if (bus_rel) begin
        addressed <= 1'b0;
      end else if (addr_hit) begin
        addressed <= 1'b1;
        rw        <= byte_in[0];
      end
      if (rx_done) rx_data <= byte_in;
    end
  end

  // Line drivers: a requested SDA value waits thddat cycles in pend/hold_cnt;
  // a stretched SCL is let go together with the first TX bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sda_o    <= 1'b1;
      scl_o    <= 1'b1;
      pend     <= 1'b0;
      pend_val <= 1'b1;
      pend_scl <= 1'b0;
      hold_cnt <= 16'd0;
      wait_tx  <= 1'b0;
    end else if (bus_rel) begin
      sda_o    <= 1'b1;
      scl_o    <= 1'b1;
      pend     <= 1'b0;
      pend_scl <= 1'b0;
      wait_tx  <= 1'b0;
    end else if (stretch) begin
      sda_o   <= 1'b1;
      scl_o   <= 1'b0;
      pend    <= 1'b0;
      wait_tx <= 1'b1;
    end else if (drv_req) begin
      wait_tx <= 1'b0;
      if (thddat == 16'd0) begin
        sda_o <= drv_val;
        pend  <= 1'b0;
        if (wait_tx) scl_o <= 1'b1;
      end else begin
        sda_o    <= 1'b1;
        pend     <= 1'b1;
        pend_val <= drv_val;
        pend_scl <= wait_tx;
        hold_cnt <= 16'd1;
      end
    end else if (rel_sda) begin
      sda_o <= 1'b1;
      pend  <= 1'b0;
    end else if (pend) begin
      if (hold_cnt >= thddat) begin
        sda_o    <= pend_val;
        pend     <= 1'b0;
        pend_scl <= 1'b0;
        if (pend_scl) scl_o <= 1'b1;
      end else if (hold_cnt != 16'hFFFF) begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slv_ctrl.sv
// Directed bench for i2c_slv_ctrl: a bit-banged I2C master on a wired-AND bus
// exercises write, read, address mismatch, stretching, repeated START and reset.
module tb_i2c_slv_ctrl;
  import i2c_slv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, ena;
  logic [6:0]  slv_addr;
  logic [15:0] thddat;
  logic        scl_m, sda_m;
  logic        scl_o, sda_o;
  logic        scl_i, sda_i;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;
  logic        addressed, rw, sta_det, sto_det, nack_det;

  int n_run = 0;
  int n_fail = 0;

  int rx_cnt = 0, tx_cnt = 0, sta_cnt = 0, sto_cnt = 0, nack_cnt = 0, sda_low = 0;
  int b_rx, b_tx, b_sta, b_sto, b_nack, b_low;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] tx_tab0 = 8'h00, tx_tab1 = 8'h00;

  assign scl_i   = scl_m & scl_o;
  assign sda_i   = sda_m & sda_o;
  assign tx_data = (tx_cnt == b_tx) ? tx_tab0 : tx_tab1;

  always #5 clk = ~clk;

  i2c_slv_ctrl #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ena       (ena),
    .slv_addr  (slv_addr),
    .thddat    (thddat),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_o     (scl_o),
    .sda_o     (sda_o),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .addressed (addressed),
    .rw        (rw),
    .sta_det   (sta_det),
    .sto_det   (sto_det),
    .nack_det  (nack_det)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      last_rx = rx_data;
    end
    if (tx_ready) tx_cnt = tx_cnt + 1;
    if (sta_det)  sta_cnt = sta_cnt + 1;
    if (sto_det)  sto_cnt = sto_cnt + 1;
    if (nack_det) nack_cnt = nack_cnt + 1;
    if (sda_o === 1'b0) sda_low = sda_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run = n_run + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rx = rx_cnt; b_tx = tx_cnt; b_sta = sta_cnt;
    b_sto = sto_cnt; b_nack = nack_cnt; b_low = sda_low;
  endtask

  task automatic clk_bit(input logic b, output logic smp);
    int t;
    sda_m = b;
    wait_cyc(20);
    scl_m = 1'b1;
    t = 0;
    while (scl_i !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("scl_release_timeout", 0, 1);
    wait_cyc(10);
    smp = sda_i;
    wait_cyc(10);
    scl_m = 1'b0;
    wait_cyc(5);
  endtask

  task automatic start_c();
    sda_m = 1'b1; wait_cyc(20);
    scl_m = 1'b1; wait_cyc(20);
    sda_m = 1'b0; wait_cyc(20);
    scl_m = 1'b0; wait_cyc(20);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_cyc(20);
    scl_m = 1'b1; wait_cyc(20);
    sda_m = 1'b1; wait_cyc(20);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(ack_bit, s);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         n;
    rstn = 1'b0; ena = 1'b1; slv_addr = 7'h42; thddat = 16'd3;
    scl_m = 1'b1; sda_m = 1'b1; tx_valid = 1'b0;
    b_rx = 0; b_tx = 0; b_sta = 0; b_sto = 0; b_nack = 0; b_low = 0;

    // Reset state
    wait_cyc(3);
    chk("rst_scl_o", 32'(scl_o), 1);
    chk("rst_sda_o", 32'(sda_o), 1);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_addressed", 32'(addressed), 0);
    chk("rst_rw", 32'(rw), 0);
    chk("rst_pulses", 32'({rx_valid, tx_ready, sta_det, sto_det, nack_det}), 0);
    rstn = 1'b1;
    wait_cyc(10);

    // Master write: address 0x42/W, data 0x84, 0xA5
    snap();
    start_c();
    write_byte(8'h84, ack);
    chk("wr_addr_ack", 32'(ack), 0);
    chk("wr_addressed", 32'(addressed), 1);
    chk("wr_rw", 32'(rw), 0);
    write_byte(8'h84, ack);
    chk("wr_d0_ack", 32'(ack), 0);
    write_byte(8'hA5, ack);
    chk("wr_d1_ack", 32'(ack), 0);
    chk("wr_rx_valid_cnt", 32'(rx_cnt - b_rx), 2);
    chk("wr_last_rx", 32'(last_rx), 'hA5);
    chk("wr_rx_data", 32'(rx_data), 'hA5);
    stop_c();
    chk("wr_addressed_after_stop", 32'(addressed), 0);
    chk("wr_sta_cnt", 32'(sta_cnt - b_sta), 1);
    chk("wr_sto_cnt", 32'(sto_cnt - b_sto), 1);

    // Master read: 0x3C acked, 0xC3 nacked
    tx_tab0 = 8'h3C; tx_tab1 = 8'hC3; tx_valid = 1'b1;
    snap();
    start_c();
    write_byte(8'h85, ack);
    chk("rd_addr_ack", 32'(ack), 0);
    chk("rd_rw", 32'(rw), 1);
    read_byte(1'b0, d);
    chk("rd_byte0", 32'(d), 'h3C);
    read_byte(1'b1, d);
    chk("rd_byte1", 32'(d), 'hC3);
    chk("rd_tx_ready_cnt", 32'(tx_cnt - b_tx), 2);
    chk("rd_nack_cnt", 32'(nack_cnt - b_nack), 1);
    chk("rd_state_ignore", 32'(dut.state), 32'(IGNORE));
    stop_c();
    tx_valid = 1'b0;
    wait_cyc(10);

    // Foreign address 0x43
    snap();
    start_c();
    write_byte(8'h86, ack);
    chk("mis_addr_nack", 32'(ack), 1);
    chk("mis_addressed", 32'(addressed), 0);
    write_byte(8'h55, ack);
    chk("mis_data_nack", 32'(ack), 1);
    chk("mis_rx_valid_cnt", 32'(rx_cnt - b_rx), 0);
    chk("mis_tx_ready_cnt", 32'(tx_cnt - b_tx), 0);
    chk("mis_sda_low_cycles", 32'(sda_low - b_low), 0);
    stop_c();
    wait_cyc(10);

    // Clock stretching while TX data is missing
    tx_tab0 = 8'h5A; tx_tab1 = 8'h5A; tx_valid = 1'b0;
    snap();
    start_c();
    write_byte(8'h85, ack);
    chk("str_addr_ack", 32'(ack), 0);
    n = 0;
    repeat (500) begin
      @(negedge clk);
      if (scl_o === 1'b0) n++;
    end
    chk("str_scl_low_cycles", 32'(n), 500);
    chk("str_no_tx_ready", 32'(tx_cnt - b_tx), 0);
    tx_valid = 1'b1;
    n = 0;
    while (scl_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    // one cycle to register tx_valid, then thddat cycles of hold
    chk("str_release_delay", 32'(n), 32'(thddat) + 1);
    read_byte(1'b1, d);
    chk("str_byte", 32'(d), 'h5A);
    stop_c();
    tx_valid = 1'b0;
    wait_cyc(10);

    // Repeated START: write one byte, then read
    tx_tab0 = 8'h96; tx_tab1 = 8'h00; tx_valid = 1'b1;
    snap();
    start_c();
    write_byte(8'h84, ack);
    chk("rs_addr_w_ack", 32'(ack), 0);
    write_byte(8'h11, ack);
    chk("rs_data_ack", 32'(ack), 0);
    chk("rs_rw_write", 32'(rw), 0);
    start_c();
    write_byte(8'h85, ack);
    chk("rs_addr_r_ack", 32'(ack), 0);
    chk("rs_rw_read", 32'(rw), 1);
    read_byte(1'b1, d);
    chk("rs_byte", 32'(d), 'h96);
    chk("rs_tx_ready_cnt", 32'(tx_cnt - b_tx), 1);
    chk("rs_sta_cnt", 32'(sta_cnt - b_sta), 2);
    stop_c();
    tx_valid = 1'b0;
    wait_cyc(10);

    // Reset during the high phase of RX bit 4
    start_c();
    write_byte(8'h84, ack);
    chk("rst_mid_addr_ack", 32'(ack), 0);
    clk_bit(1'b1, ack);
    clk_bit(1'b0, ack);
    clk_bit(1'b1, ack);
    sda_m = 1'b1;
    wait_cyc(20);
    scl_m = 1'b1;
    wait_cyc(10);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_scl_o", 32'(scl_o), 1);
    chk("rst_mid_sda_o", 32'(sda_o), 1);
    chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
    chk("rst_mid_addressed", 32'(addressed), 0);
    wait_cyc(3);
    rstn = 1'b1;
    wait_cyc(5);
    scl_m = 1'b0;
    wait_cyc(10);
    snap();
    start_c();
    write_byte(8'h84, ack);
    chk("rst_after_addr_ack", 32'(ack), 0);
    chk("rst_after_addressed", 32'(addressed), 1);
    write_byte(8'h77, ack);
    chk("rst_after_data_ack", 32'(ack), 0);
    chk("rst_after_rx_data", 32'(rx_data), 'h77);
    stop_c();
    wait_cyc(10);

    // Core disabled: bus traffic is ignored entirely
    ena = 1'b0;
    snap();
    start_c();
    write_byte(8'h84, ack);
    chk("dis_addr_nack", 32'(ack), 1);
    chk("dis_sta_cnt", 32'(sta_cnt - b_sta), 0);
    chk("dis_rx_valid_cnt", 32'(rx_cnt - b_rx), 0);
    stop_c();
    chk("dis_sto_cnt", 32'(sto_cnt - b_sto), 0);
    ena = 1'b1;
    wait_cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
